// File: rtl/nibble_serial_addsub_ctrl_if.sv
// rtl/nibble_serial_addsub_ctrl_if.sv - request/result handshake bundle for the nibble-serial adder/subtractor
//
// Signals (W = 4*NIBBLES):
//   in_valid, in_ready   request handshake
//   A, B, sub            operands and operation select, sampled at accept
//   out_valid, out_ready result handshake
//   S, Cout              result and carry out of bit W-1
//   Ovf                  signed overflow, only when ADDSUB_OVF_EN is defined
// Modports: master drives requests and consumes results; slave is the block.
interface nibble_serial_addsub_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           sub;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   S;
    logic           Cout;
`ifdef ADDSUB_OVF_EN
    logic           Ovf;

    modport master (
        output in_valid, A, B, sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );
`else
    modport master (
        output in_valid, A, B, sub, out_ready,
        input  in_ready, out_valid, S, Cout
    );

    modport slave (
        input  in_valid, A, B, sub, out_ready,
        output in_ready, out_valid, S, Cout
    );
`endif
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// rtl/nibble_serial_addsub_ctrl.sv - nibble-serial W-bit adder/subtractor sharing one 4-bit ripple slice
//
// Parameter: NIBBLES (2..8), operand width W = 4*NIBBLES.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous abort, wins over both handshakes
//   bus    nibble_serial_addsub_ctrl_if.slave (request, result, S/Cout[/Ovf])
// Optional feature macro: ADDSUB_OVF_EN adds the signed overflow output Ovf.
//
// One request is accepted in IDLE, then one nibble is processed per RUN cycle
// (least significant first), and the result is held in DONE until consumed.
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    nibble_serial_addsub_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           sub_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic [W-1:0]   s_q;
`ifdef ADDSUB_OVF_EN
    logic           ovf_q;
`endif

    logic           accept;
    logic           step;
    logic           last_nib;

    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [3:0]     sum_nib;
    logic [4:0]     c;

    assign last_nib = (idx_q == IW'(NIBBLES - 1));

    // Shared 4-bit ripple slice. The B nibble is inverted for subtraction and
    // the initial carry is seeded with sub at accept, giving A + ~B + 1.
    always_comb begin
        a_nib   = a_q[{idx_q, 2'b00} +: 4];
        b_nib   = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
        c       = '0;
        sum_nib = '0;
        c[0]    = carry_q;
        for (int k = 0; k < 4; k++) begin
            sum_nib[k] = a_nib[k] ^ b_nib[k] ^ c[k];
            c[k+1]     = (a_nib[k] & b_nib[k]) | ((a_nib[k] ^ b_nib[k]) & c[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. in_ready is low in DONE, so the
    // consume edge can never also be an accept edge.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        step          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (!flush && bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (last_nib) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (flush || bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            sub_q   <= bus.sub;
            idx_q   <= '0;
            carry_q <= bus.sub;
            s_q     <= '0;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (step) begin
            s_q[{idx_q, 2'b00} +: 4] <= sum_nib;
            carry_q                  <= c[4];
            idx_q                    <= idx_q + IW'(1);
`ifdef ADDSUB_OVF_EN
            // Carry into the top bit differs from carry out only on signed overflow.
            if (last_nib) begin
                ovf_q <= c[3] ^ c[4];
            end
`endif
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = carry_q;
`ifdef ADDSUB_OVF_EN
    assign bus.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb/tb_nibble_serial_addsub_ctrl.sv - self-checking bench for nibble_serial_addsub_ctrl
`timescale 1ns/1ps
module tb_nibble_serial_addsub_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    nibble_serial_addsub_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic, result in [W-1:0], carry in [W].
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    // Reference signed overflow: true signed result outside the W-bit range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = s ? (sa - sb) : (sa + sb);
        return (res > (longint'(1) <<< (W-1)) - 1) || (res < -(longint'(1) <<< (W-1)));
    endfunction

    // Issue one request at a negedge, wait for the result, capture and consume it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output logic [W-1:0] rs, output logic rc, output logic ro);
        lat = -1; rs = '0; rc = 1'b0; ro = 1'b0;
        bus.A = a; bus.B = b; bus.sub = s; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.sub = 1'($urandom);
        for (int n = 1; n <= 3 * NIBBLES; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat > 0) begin
            rs = bus.S; rc = bus.Cout;
`ifdef ADDSUB_OVF_EN
            ro = bus.Ovf;
`endif
            bus.out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.S, bus.Cout} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b S=%h Cout=%b want 1 0 0000 0",
                     bus.in_ready, bus.out_valid, bus.S, bus.Cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{16'h1234, 16'h0005, 16'h0007, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [W-1:0] vb [6] = '{16'h0FCD, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
        logic         vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [6] = '{16'h2201, 16'hFFFE, 16'h0002, 16'h0000, 16'h8000, 16'h7FFF};
        logic         ec [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat; logic [W-1:0] rs; logic rc, ro;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], lat, rs, rc, ro);
            checks++;
            if (lat !== NIBBLES) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, NIBBLES);
            end
            checks++;
            if ({rs, rc} !== {es[i], ec[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d] got S=%h Cout=%b want S=%h Cout=%b", i, rs, rc, es[i], ec[i]);
            end
`ifdef ADDSUB_OVF_EN
            checks++;
            if (ro !== eo[i]) begin
                errors++;
                $display("FAIL directed_ovf[%0d] got %b want %b", i, ro, eo[i]);
            end
`else
            if (ro !== 1'b0 && eo[i] === 1'b1) ;
`endif
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] rs, a, b; logic rc, ro, s; logic [W:0] e;
        for (int i = 0; i < 16; i++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom);
            e = ref_sum(a, b, s);
            run_op(a, b, s, lat, rs, rc, ro);
            checks++;
            if (lat !== NIBBLES || {rc, rs} !== e) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h sub=%b got lat=%0d S=%h Cout=%b want lat=%0d S=%h Cout=%b",
                         i, a, b, s, lat, rs, rc, NIBBLES, e[W-1:0], e[W]);
            end
`ifdef ADDSUB_OVF_EN
            checks++;
            if (ro !== ref_ovf(a, b, s)) begin
                errors++;
                $display("FAIL random_ovf[%0d] got %b want %b", i, ro, ref_ovf(a, b, s));
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, a2, b2, rs; logic s, s2, rc, ro; logic [W:0] e, e2; int lat; bit seen;
        a = W'($urandom); b = W'($urandom); s = 1'($urandom); e = ref_sum(a, b, s);
        a2 = W'($urandom); b2 = W'($urandom); s2 = 1'($urandom); e2 = ref_sum(a2, b2, s2);
        bus.A = a; bus.B = b; bus.sub = s; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 3 * NIBBLES && !seen; n++) begin
            @(posedge clk); @(negedge clk);
            seen = bus.out_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_result_timeout got out_valid=0 want 1");
        end
        // Second request waits while the first result is stalled.
        bus.A = a2; bus.B = b2; bus.sub = s2; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.Cout, bus.S} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got out_valid=%b in_ready=%b S=%h Cout=%b want 1 0 S=%h Cout=%b",
                         k, bus.out_valid, bus.in_ready, bus.S, bus.Cout, e[W-1:0], e[W]);
            end
            @(posedge clk); @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_no_accept_on_consume got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        run_op(a2, b2, s2, lat, rs, rc, ro);
        checks++;
        if (lat !== NIBBLES || {rc, rs} !== e2) begin
            errors++;
            $display("FAIL bp_second got lat=%0d S=%h Cout=%b want lat=%0d S=%h Cout=%b",
                     lat, rs, rc, NIBBLES, e2[W-1:0], e2[W]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        bit prev_ready;
        int last_acc = -1;
        int results  = 0;
        prev_ready = bus.in_ready;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.sub = 1'($urandom);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int cyc = 1; cyc <= 40 + 3 * NIBBLES; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (prev_ready && bus.in_valid) begin
                q.push_back(ref_sum(bus.A, bus.B, bus.sub));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== NIBBLES + 2) begin
                        errors++;
                        $display("FAIL b2b_interval got %0d want %0d", cyc - last_acc, NIBBLES + 2);
                    end
                end
                last_acc = cyc;
                bus.A = W'($urandom); bus.B = W'($urandom); bus.sub = 1'($urandom);
            end
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_result got S=%h want none", bus.S);
                end else begin
                    e = q.pop_front();
                    results++;
                    if ({bus.Cout, bus.S} !== e) begin
                        errors++;
                        $display("FAIL b2b_result got S=%h Cout=%b want S=%h Cout=%b", bus.S, bus.Cout, e[W-1:0], e[W]);
                    end
                end
            end
            prev_ready = bus.in_ready;
            if (cyc == 40) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (q.size() != 0 || results < 5) begin
            errors++;
            $display("FAIL b2b_drain got pending=%0d results=%0d want 0 and >=5", q.size(), results);
        end
    endtask

    task automatic test_abort();
        int lat; logic [W-1:0] rs; logic rc, ro; bit seen;
        for (int mode = 0; mode < 2; mode++) begin
            bus.A = 16'h1234; bus.B = 16'h1111; bus.sub = 1'b0; bus.in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk); @(negedge clk);
            if (mode == 0) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({bus.in_ready, bus.out_valid, bus.S, bus.Cout} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0}) begin
                    errors++;
                    $display("FAIL abort_reset_immediate got in_ready=%b out_valid=%b S=%h Cout=%b want 1 0 0000 0",
                             bus.in_ready, bus.out_valid, bus.S, bus.Cout);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                flush = 1'b1;
                @(posedge clk); @(negedge clk);
                flush = 1'b0;
                checks++;
                if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                    errors++;
                    $display("FAIL abort_flush_idle got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
                end
            end
            seen = 1'b0;
            for (int n = 0; n < 3 * NIBBLES; n++) begin
                @(posedge clk); @(negedge clk);
                seen |= bus.out_valid;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL abort_no_result[%0d] got out_valid=1 want 0", mode);
            end
            run_op(16'h0001, 16'h0001, 1'b0, lat, rs, rc, ro);
            checks++;
            if (lat !== NIBBLES || rs !== 16'h0002 || rc !== 1'b0) begin
                errors++;
                $display("FAIL abort_next_op[%0d] got lat=%0d S=%h Cout=%b want lat=%0d S=0002 Cout=0", mode, lat, rs, rc, NIBBLES);
            end
        end
        // Flush beats accept in IDLE.
        bus.A = 16'h0003; bus.B = 16'h0004; bus.sub = 1'b0; bus.in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0; flush = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 3 * NIBBLES; n++) begin
            seen |= bus.out_valid | ~bus.in_ready;
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_over_accept got a started operation want none");
        end
        // Flush beats the result handshake in DONE.
        bus.A = 16'h0003; bus.B = 16'h0004; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        for (int n = 0; n < NIBBLES; n++) begin
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.S !== 16'h0007) begin
            errors++;
            $display("FAIL flush_done_setup got out_valid=%b S=%h want 1 0007", bus.out_valid, bus.S);
        end
        flush = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_in_done got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sub       = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/nibble_serial_addsub_ctrl.md
NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand (legal 2..8); W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, operand request valid.
REQ-005 The block SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 The block SHALL have ports A, input, W, and B, input, W, the operands; sampled only at accept.
REQ-007 The block SHALL have port sub, input, 1, 0 for A+B and 1 for A-B; sampled only at accept.
REQ-008 The block SHALL have port flush, input, 1, synchronous abort.
REQ-009 The block SHALL have port out_valid, output, 1, result valid.
REQ-010 The block SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high at a rising edge.
REQ-011 The block SHALL have ports S, output, W, the result, and Cout, output, 1, the carry out of bit W-1.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE with one internal 4-bit ripple-carry slice shared across all nibbles.
REQ-013 In IDLE, in_ready SHALL be 1; on accept, the block SHALL latch A, B and sub, clear the nibble index to 0, set carry to sub, and go to RUN.
REQ-014 Each RUN cycle SHALL add nibble i of A, nibble i of B XOR {4{sub}}, and the stored carry, write the sum to S[4i+3:4i], store the carry out, and increment i.
REQ-015 After the nibble NIBBLES-1 cycle, the block SHALL go to DONE; out_valid SHALL rise exactly NIBBLES cycles after the accept edge.
REQ-016 In DONE, out_valid SHALL be 1 and S/Cout SHALL be held stable until out_ready is high; the handshake edge SHALL return the block to IDLE.
REQ-017 in_ready SHALL be 0 in RUN and DONE; no accept SHALL occur in the cycle a result is consumed (back-to-back throughput = NIBBLES+2 cycles).
REQ-018 Result SHALL be (A + ~B + 1) mod 2^W for sub=1 and (A + B) mod 2^W for sub=0; Cout=1 for sub=1 means no borrow.
REQ-019 flush high at a rising edge SHALL force IDLE from any state, drop out_valid, and discard the operation; flush SHALL take priority over accept and over the out handshake in the same cycle.
REQ-020 S and Cout SHALL be undefined-free: during RUN they show partial progress, and only the DONE value is architecturally valid.

Reset
REQ-021 With rst_n low, the block SHALL enter IDLE immediately, with in_ready=1, out_valid=0, S=0, Cout=0, nibble index 0, carry 0, and Ovf=0 if present.
REQ-022 Reset asserted mid-RUN or in DONE SHALL discard the operation with no result ever presented; operation SHALL resume on the first edge after rst_n rises.

Configuration
REQ-023 With macro ADDSUB_OVF_EN defined, the block SHALL have an extra output port Ovf, 1 bit, set in DONE to the signed overflow, i.e. the carry into bit W-1 XOR Cout, and valid with out_valid.
REQ-024 Without ADDSUB_OVF_EN, the port Ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (NIBBLES=4)
REQ-025 Add: A=0x1234, B=0x0FCD, sub=0 -> out_valid 4 cycles after accept, S=0x2201, Cout=0.
REQ-026 Subtract with borrow: A=0x0005, B=0x0007, sub=1 -> S=0xFFFE, Cout=0; A=0x0007, B=0x0005, sub=1 -> S=0x0002, Cout=1.
REQ-027 Wrap and overflow: A=0xFFFF, B=0x0001, sub=0 -> S=0x0000, Cout=1, Ovf=0; A=0x7FFF, B=0x0001 -> S=0x8000, Cout=0, Ovf=1 (ADDSUB_OVF_EN builds only).
REQ-028 Backpressure: out_ready held 0 for 5 cycles in DONE -> S/out_valid stable, in_ready=0 throughout; a new in_valid is accepted only after the handshake.
REQ-029 Abort: rst_n pulsed low, then separately flush pulsed, each at the 2nd RUN cycle -> immediate/next-edge IDLE, out_valid never asserts, and the next request A=0x0001, B=0x0001 gives S=0x0002.
